// File: rtl/arp_cache.sv
// ARP cache: maps IPv4 protocol addresses to MAC addresses.
// It is a Wishbone classic slave with a linear scan, per-entry ageing and expiry, and a flush.
// A store that misses replaces the lowest invalid entry, or else the oldest entry.
module arp_cache #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AGE_W     = 8,
    parameter int unsigned TICK_DIV  = 125000,
    parameter int unsigned ENTRY_TTL = 200
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    input  logic [31:0]              prot_addr_i,
    input  logic [47:0]              hw_addr_i,
    output logic [47:0]              hw_addr_o,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   valid_count_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam int unsigned AW1   = AGE_W + 1;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);
    localparam logic [PRE_W-1:0] PreMax  = PRE_W'(TICK_DIV - 1);
    localparam logic [AGE_W:0]   Ttl     = AW1'(ENTRY_TTL);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StScan = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    // Entry storage
    logic [31:0]      prot_q [DEPTH];
    logic [47:0]      hw_q   [DEPTH];
    logic [AGE_W-1:0] age_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;

    // Transaction and control state
    logic [1:0]       state_q, state_d;
    logic             we_q, hit_q, flush_pend_q;
    logic [31:0]      addr_q;
    logic [47:0]      hwin_q, hw_addr_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] vic_idx_q, vic_idx_d;
    logic             vic_inv_q, vic_inv_d;
    logic [AGE_W-1:0] vic_age_q, vic_age_d;
    logic [PRE_W-1:0] presc_q;
    logic [IDX_W:0]   count_q, pop;

    logic             tick, busy, flush_now, start, abort, scan_done;
    logic             cur_live, cur_hit, wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [AGE_W:0]   age_inc [DEPTH];
    logic [DEPTH-1:0] expire;

    // Age prescaler: tick is high for one cycle on every wrap
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i)             presc_q <= '0;
        else if (presc_q == PreMax) presc_q <= '0;
        else                        presc_q <= presc_q + PRE_W'(1);
    end

    assign tick = (presc_q == PreMax);

    // Entries whose age reaches the TTL on this tick are already dead for comparison
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_inc[i] = {1'b0, age_q[i]} + AW1'(1);
            expire[i]  = tick && valid_q[i] && (age_inc[i] >= Ttl);
        end
    end

    // Compare, victim tracking and handshake decode
    always_comb begin
        busy      = wb_cyc_i && wb_stb_i;
        flush_now = (state_q == StIdle) && (flush_pend_q || flush_i);
        start     = (state_q == StIdle) && !flush_now && busy;
        abort     = (state_q == StScan) && !busy;
        cur_live  = valid_q[idx_q] && !expire[idx_q];
        cur_hit   = cur_live && (prot_q[idx_q] == addr_q);
        scan_done = (state_q == StScan) && busy && (cur_hit || idx_q == LastIdx);

        vic_idx_d = vic_idx_q;
        vic_inv_d = vic_inv_q;
        vic_age_d = vic_age_q;
        if (!vic_inv_q) begin
            if (!cur_live) begin
                vic_idx_d = idx_q;
                vic_inv_d = 1'b1;
            end else if (age_q[idx_q] > vic_age_q) begin
                vic_idx_d = idx_q;
                vic_age_d = age_q[idx_q];
            end
        end

        wr_en  = scan_done && we_q;
        wr_idx = cur_hit ? idx_q : vic_idx_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StScan;
            StScan:  if (abort) state_d = StIdle;
                     else if (scan_done) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Transaction registers, flush latch, hit data and victim tracking
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q      <= StIdle;
            flush_pend_q <= 1'b0;
            we_q         <= 1'b0;
            hit_q        <= 1'b0;
            addr_q       <= '0;
            hwin_q       <= '0;
            hw_addr_q    <= '0;
            idx_q        <= '0;
            vic_idx_q    <= '0;
            vic_inv_q    <= 1'b0;
            vic_age_q    <= '0;
        end else begin
            state_q <= state_d;
            if (flush_now)                      flush_pend_q <= 1'b0;
            else if (flush_i && state_q != StIdle) flush_pend_q <= 1'b1;
            if (start) begin
                we_q      <= wb_we_i;
                addr_q    <= prot_addr_i;
                hwin_q    <= hw_addr_i;
                idx_q     <= '0;
                vic_idx_q <= '0;
                vic_inv_q <= 1'b0;
                vic_age_q <= '0;
            end else if (state_q == StScan && busy) begin
                vic_idx_q <= vic_idx_d;
                vic_inv_q <= vic_inv_d;
                vic_age_q <= vic_age_d;
                if (scan_done) hit_q <= cur_hit;
                else           idx_q <= idx_q + IDX_W'(1);
            end
            if (scan_done && !we_q && cur_hit) hw_addr_q <= hw_q[idx_q];
        end
    end

    // Entry update: ageing/expiry, flush, then a store write which overrides the tick
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                prot_q[i] <= '0;
                hw_q[i]   <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (tick && valid_q[i]) begin
                    age_q[i] <= age_inc[i][AGE_W-1:0];
                    if (expire[i]) valid_q[i] <= 1'b0;
                end
                if (flush_now) valid_q[i] <= 1'b0;
                if (wr_en && wr_idx == IDX_W'(i)) begin
                    prot_q[i]  <= addr_q;
                    hw_q[i]    <= hwin_q;
                    valid_q[i] <= 1'b1;
                    age_q[i]   <= '0;
                end
            end
        end
    end

    // Population count of valid bits, registered
    always_comb begin
        pop = '0;
        for (int i = 0; i < DEPTH; i++) pop = pop + {{IDX_W{1'b0}}, valid_q[i]};
    end

    // Registered valid count
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) count_q <= '0;
        else           count_q <= pop;
    end

    assign wb_ack_o      = (state_q == StResp) && (we_q || hit_q);
    assign wb_err_o      = (state_q == StResp) && !we_q && !hit_q;
    assign hw_addr_o     = hw_addr_q;
    assign valid_count_o = count_q;

endmodule

// File: tb/tb_arp_cache.sv
// Directed testbench for arp_cache: a main instance plus a fast-expiry instance.
module tb_arp_cache;

    logic        clk, rst_n, cyc, stb, we, flush, sel, flush_e;
    logic [31:0] prot;
    logic [47:0] hw;
    logic        stb_m, stb_e;
    logic        ack_m, err_m, ack_e, err_e;
    logic [47:0] hwo_m, hwo_e;
    logic [3:0]  cnt_m, cnt_e;
    int          n_cmp, n_bad;
    int          rc;
    logic        ra, re;
    logic [47:0] rh;

    assign stb_m = stb & ~sel;
    assign stb_e = stb & sel;

    arp_cache #(.DEPTH(8), .AGE_W(8), .TICK_DIV(32), .ENTRY_TTL(200)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb_m), .wb_we_i(we),
        .wb_ack_o(ack_m), .wb_err_o(err_m), .prot_addr_i(prot), .hw_addr_i(hw),
        .hw_addr_o(hwo_m), .flush_i(flush), .valid_count_o(cnt_m)
    );

    arp_cache #(.DEPTH(8), .AGE_W(8), .TICK_DIV(4), .ENTRY_TTL(3)) dut_e (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb_e), .wb_we_i(we),
        .wb_ack_o(ack_e), .wb_err_o(err_e), .prot_addr_i(prot), .hw_addr_i(hw),
        .hw_addr_o(hwo_e), .flush_i(flush_e), .valid_count_o(cnt_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run one transaction; report the cycle of the first ack/err (-1 if none within 20)
    task automatic run_txn(input logic s, input logic w, input logic [31:0] p,
                           input logic [47:0] h, output int cn, output logic a,
                           output logic e, output logic [47:0] hs);
        @(negedge clk);
        sel = s; cyc = 1'b1; stb = 1'b1; we = w; prot = p; hw = h;
        cn = -1; a = 1'b0; e = 1'b0; hs = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if ((s ? (ack_e | err_e) : (ack_m | err_m)) === 1'b1) begin
                cn = n;
                a  = s ? ack_e : ack_m;
                e  = s ? err_e : err_m;
                hs = s ? hwo_e : hwo_m;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if ({ack_m, err_m} !== 2'b00) begin n_bad++;
            $display("FAIL reset_handshake: ack/err %b required 00", {ack_m, err_m}); end
        n_cmp++; if (hwo_m !== 48'h0) begin n_bad++;
            $display("FAIL reset_hw: got %h required 0", hwo_m); end
        n_cmp++; if (cnt_m !== 4'd0) begin n_bad++;
            $display("FAIL reset_count: got %0d required 0", cnt_m); end
        run_txn(1'b0, 1'b0, 32'h0A000005, 48'h0, rc, ra, re, rh);
        n_cmp++; if (rc !== 9 || ra !== 1'b0 || re !== 1'b1) begin n_bad++;
            $display("FAIL reset_miss: cycle %0d ack %b err %b required cycle 9 ack 0 err 1",
                     rc, ra, re); end
        n_cmp++; if (rh !== 48'h0) begin n_bad++;
            $display("FAIL reset_miss_hw: got %h required 0", rh); end
    endtask

    task automatic test_store_lookup();
        run_txn(1'b0, 1'b1, 32'h0A000005, 48'h001422aabbcc, rc, ra, re, rh);
        n_cmp++; if (rc !== 9 || ra !== 1'b1 || re !== 1'b0) begin n_bad++;
            $display("FAIL store_miss: cycle %0d ack %b err %b required cycle 9 ack 1 err 0",
                     rc, ra, re); end
        @(negedge clk);
        n_cmp++; if (cnt_m !== 4'd1) begin n_bad++;
            $display("FAIL store_count: got %0d required 1", cnt_m); end
        run_txn(1'b0, 1'b0, 32'h0A000005, 48'h0, rc, ra, re, rh);
        n_cmp++; if (rc !== 2 || ra !== 1'b1 || re !== 1'b0) begin n_bad++;
            $display("FAIL lookup_hit: cycle %0d ack %b err %b required cycle 2 ack 1 err 0",
                     rc, ra, re); end
        n_cmp++; if (rh !== 48'h001422aabbcc) begin n_bad++;
            $display("FAIL lookup_hit_hw: got %h required 001422aabbcc", rh); end
    endtask

    task automatic test_replacement();
        for (int i = 1; i < 8; i++) begin
            run_txn(1'b0, 1'b1, 32'h0A000100 + i, 48'h020000000000 + 48'(i), rc, ra, re, rh);
            n_cmp++; if (rc !== 9 || ra !== 1'b1) begin n_bad++;
                $display("FAIL fill_%0d: cycle %0d ack %b required cycle 9 ack 1", i, rc, ra); end
        end
        repeat (96) @(negedge clk);
        run_txn(1'b0, 1'b1, 32'h0A000102, 48'h030000000002, rc, ra, re, rh);
        n_cmp++; if (rc !== 4 || ra !== 1'b1) begin n_bad++;
            $display("FAIL refresh: cycle %0d ack %b required cycle 4 ack 1", rc, ra); end
        run_txn(1'b0, 1'b1, 32'h0A000200, 48'h040000000009, rc, ra, re, rh);
        n_cmp++; if (rc !== 9 || ra !== 1'b1) begin n_bad++;
            $display("FAIL ninth_store: cycle %0d ack %b required cycle 9 ack 1", rc, ra); end
        @(negedge clk);
        n_cmp++; if (cnt_m !== 4'd8) begin n_bad++;
            $display("FAIL replace_count: got %0d required 8", cnt_m); end
        run_txn(1'b0, 1'b0, 32'h0A000005, 48'h0, rc, ra, re, rh);
        n_cmp++; if (rc !== 9 || re !== 1'b1 || ra !== 1'b0) begin n_bad++;
            $display("FAIL evicted_lookup: cycle %0d ack %b err %b required cycle 9 err 1",
                     rc, ra, re); end
        run_txn(1'b0, 1'b0, 32'h0A000200, 48'h0, rc, ra, re, rh);
        n_cmp++; if (rc !== 2 || ra !== 1'b1 || rh !== 48'h040000000009) begin n_bad++;
            $display("FAIL ninth_in_entry0: cycle %0d ack %b hw %h required cycle 2 ack 1 hw 040000000009",
                     rc, ra, rh); end
        run_txn(1'b0, 1'b0, 32'h0A000102, 48'h0, rc, ra, re, rh);
        n_cmp++; if (rc !== 4 || ra !== 1'b1 || rh !== 48'h030000000002) begin n_bad++;
            $display("FAIL refreshed_hw: cycle %0d ack %b hw %h required cycle 4 ack 1 hw 030000000002",
                     rc, ra, rh); end
    endtask

    task automatic test_flush_busy();
        int seen;
        logic [47:0] h;
        @(negedge clk);
        sel = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; prot = 32'h0A000103;
        seen = -1; h = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            flush = (n == 2);
            if ((ack_m | err_m) === 1'b1) begin seen = n; h = hwo_m; break; end
        end
        flush = 1'b0; cyc = 1'b0; stb = 1'b0;
        n_cmp++; if (seen !== 5 || h !== 48'h020000000003) begin n_bad++;
            $display("FAIL flush_busy_ack: cycle %0d hw %h required cycle 5 hw 020000000003",
                     seen, h); end
        @(negedge clk);
        n_cmp++; if (cnt_m !== 4'd8) begin n_bad++;
            $display("FAIL flush_count_before: got %0d required 8", cnt_m); end
        repeat (2) @(negedge clk);
        n_cmp++; if (cnt_m !== 4'd0) begin n_bad++;
            $display("FAIL flush_count_after: got %0d required 0", cnt_m); end
        run_txn(1'b0, 1'b0, 32'h0A000101, 48'h0, rc, ra, re, rh);
        n_cmp++; if (rc !== 9 || re !== 1'b1) begin n_bad++;
            $display("FAIL flushed_lookup: cycle %0d err %b required cycle 9 err 1", rc, re); end
    endtask

    task automatic test_abort();
        int resp;
        @(negedge clk);
        sel = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1; prot = 32'h0A000300; hw = 48'h0A0B0C0D0E0F;
        resp = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if ((ack_m | err_m) === 1'b1) resp++;
            if (n == 3) begin cyc = 1'b0; stb = 1'b0; end
        end
        n_cmp++; if (resp !== 0) begin n_bad++;
            $display("FAIL abort_resp: got %0d responses required 0", resp); end
        n_cmp++; if (cnt_m !== 4'd0) begin n_bad++;
            $display("FAIL abort_count: got %0d required 0", cnt_m); end
        run_txn(1'b0, 1'b0, 32'h0A000300, 48'h0, rc, ra, re, rh);
        n_cmp++; if (rc !== 9 || re !== 1'b1) begin n_bad++;
            $display("FAIL abort_no_write: cycle %0d err %b required cycle 9 err 1", rc, re); end
    endtask

    task automatic test_expiry();
        run_txn(1'b1, 1'b1, 32'h0A000005, 48'h00AABBCCDDEE, rc, ra, re, rh);
        n_cmp++; if (rc !== 9 || ra !== 1'b1) begin n_bad++;
            $display("FAIL exp_store: cycle %0d ack %b required cycle 9 ack 1", rc, ra); end
        @(negedge clk);
        n_cmp++; if (cnt_e !== 4'd1) begin n_bad++;
            $display("FAIL exp_count_live: got %0d required 1", cnt_e); end
        repeat (13) @(negedge clk);
        n_cmp++; if (cnt_e !== 4'd0) begin n_bad++;
            $display("FAIL exp_count_dead: got %0d required 0", cnt_e); end
        run_txn(1'b1, 1'b0, 32'h0A000005, 48'h0, rc, ra, re, rh);
        n_cmp++; if (rc !== 9 || re !== 1'b1 || ra !== 1'b0) begin n_bad++;
            $display("FAIL exp_lookup: cycle %0d ack %b err %b required cycle 9 err 1", rc, ra, re); end
        sel = 1'b0;
    endtask

    task automatic test_async_reset();
        run_txn(1'b0, 1'b1, 32'h0A000400, 48'h000011112222, rc, ra, re, rh);
        run_txn(1'b0, 1'b0, 32'h0A000400, 48'h0, rc, ra, re, rh);
        n_cmp++; if (rc !== 2 || rh !== 48'h000011112222) begin n_bad++;
            $display("FAIL pre_reset_hit: cycle %0d hw %h required cycle 2 hw 000011112222",
                     rc, rh); end
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; prot = 32'h0A000500;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({ack_m, err_m} !== 2'b00 || hwo_m !== 48'h0 || cnt_m !== 4'd0) begin
            n_bad++;
            $display("FAIL async_reset: ack %b err %b hw %h count %0d required all 0",
                     ack_m, err_m, hwo_m, cnt_m); end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1'b0, 1'b0, 32'h0A000400, 48'h0, rc, ra, re, rh);
        n_cmp++; if (rc !== 9 || re !== 1'b1) begin n_bad++;
            $display("FAIL post_reset_lookup: cycle %0d err %b required cycle 9 err 1", rc, re); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; flush = 1'b0; flush_e = 1'b0;
        sel = 1'b0; prot = '0; hw = '0;
        #23 rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_store_lookup();
        test_replacement();
        test_flush_busy();
        test_abort();
        test_expiry();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
